// File: rtl/npc_pkg.sv
// Shared constants, fetch-state encoding and helper for the instruction fetch slice.
// XLEN is fixed at 32. The IFU_EBREAK_HALT_EN build option is consumed in ifu_fetch.
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] INST_EBREAK      = 32'h0010_0073;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_HALT = 2'd3
    } fetch_state_e;

    // One delivered instruction as presented to decode.
    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
        logic            err;
    } fetch_pkt_t;

    // Sequential successor; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] seq_next_pc(input logic [XLEN-1:0] cur);
        return cur + PC_STEP;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: imem request/response, instruction delivery to the core,
// redirect from execute and halt status. master = fetch unit, slave = environment.
interface ifu_fetch_if;
    import npc_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;

    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic            fetch_err;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            halted;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, instruction, pc, fetch_err,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, instruction, pc, fetch_err,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  halted
    );

endinterface

// File: rtl/ifu_pc_reg.sv
// Architectural fetch PC register: holds, takes a redirect target, or steps by 4.
// Redirect always wins over the sequential step.
module ifu_pc_reg
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_redirect,
    input  logic            load_seq,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] seq_base,
    output logic [XLEN-1:0] fetch_pc
);

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] fetch_pc_next;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (load_redirect) begin
            fetch_pc_next = redirect_pc;
        end else if (load_seq) begin
            fetch_pc_next = seq_next_pc(seq_base);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    assign fetch_pc = fetch_pc_reg;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read, held {instruction, pc} for the core,
// redirects from execute. Define IFU_EBREAK_HALT_EN to stop fetching after an ebreak is consumed.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);

    localparam logic [1:0] REQ  = FS_REQ;
    localparam logic [1:0] WAIT = FS_WAIT;
    localparam logic [1:0] HOLD = FS_HOLD;
`ifdef IFU_EBREAK_HALT_EN
    localparam logic [1:0] HALT = FS_HALT;
`endif

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic            drop_reg;
    logic            drop_next;
    fetch_pkt_t      pkt_reg;
    fetch_pkt_t      pkt_next;

    logic [XLEN-1:0] fetch_pc;
    logic            pc_load_redirect;
    logic            pc_load_seq;

    ifu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .load_redirect (pc_load_redirect),
        .load_seq      (pc_load_seq),
        .redirect_pc   (bus.redirect_pc),
        .seq_base      (pkt_reg.pc),
        .fetch_pc      (fetch_pc)
    );

    always_comb begin
        state_next       = state_reg;
        drop_next        = drop_reg;
        pkt_next         = pkt_reg;
        pc_load_redirect = 1'b0;
        pc_load_seq      = 1'b0;

        case (state_reg)
            REQ: begin
                pc_load_redirect = bus.redirect_valid;
                // A redirect in the accept cycle still lets the old-address request go out;
                // its response is marked for discard.
                if (bus.imem_req_ready) begin
                    state_next = WAIT;
                    drop_next  = bus.redirect_valid;
                end
            end

            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_load_redirect = 1'b1;
                    drop_next        = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    if (drop_reg || bus.redirect_valid) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        pkt_next.instruction = bus.imem_rsp_data;
                        pkt_next.pc          = fetch_pc;
                        pkt_next.err         = bus.imem_rsp_err;
                        state_next           = HOLD;
                    end
                end
            end

            HOLD: begin
                if (bus.inst_ready) begin
                    pc_load_redirect = bus.redirect_valid;
                    pc_load_seq      = !bus.redirect_valid;
                    state_next       = REQ;
`ifdef IFU_EBREAK_HALT_EN
                    if (pkt_reg.instruction == INST_EBREAK) begin
                        state_next = HALT;
                    end
`endif
                end else if (bus.redirect_valid) begin
                    // Held instruction is on the wrong path; drop it unconsumed.
                    pc_load_redirect = 1'b1;
                    state_next       = REQ;
                end
            end

`ifdef IFU_EBREAK_HALT_EN
            HALT: begin
                state_next = HALT;
            end
`endif

            default: begin
                state_next = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= REQ;
            drop_reg            <= 1'b0;
            pkt_reg.instruction <= '0;
            pkt_reg.pc          <= RESET_PC;
            pkt_reg.err         <= 1'b0;
        end else begin
            state_reg <= state_next;
            drop_reg  <= drop_next;
            pkt_reg   <= pkt_next;
        end
    end

    assign bus.imem_req_valid = (state_reg == REQ) && !rst;
    assign bus.imem_req_addr  = fetch_pc;

    assign bus.inst_valid     = (state_reg == HOLD);
    assign bus.instruction    = pkt_reg.instruction;
    assign bus.pc             = pkt_reg.pc;
    assign bus.fetch_err      = pkt_reg.err;

`ifdef IFU_EBREAK_HALT_EN
    assign bus.halted = (state_reg == HALT);
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit that sits directly upstream of the single-cycle core top.
- Owns the architectural PC register and issues word reads to instruction memory over a valid/ready request plus valid response interface.
- Presents {instruction, pc} to decode/execute over a valid/ready handshake.
- Takes next-PC redirects (jal/jalr/branch) back from execute.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- XLEN, 32, address and instruction width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word address of fetch
- imem_rsp_valid  in  1  read data valid; single-cycle pulse, at least 1 cycle after request accept
- imem_rsp_data  in  XLEN  fetched instruction word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  instruction/pc valid to core
- inst_ready  in  1  core consumes instruction
- instruction  out  XLEN  fetched instruction
- pc  out  XLEN  address of instruction
- fetch_err  out  1  instruction carries an access fault
- redirect_valid  in  1  replace sequential next PC
- redirect_pc  in  XLEN  redirect target
- halted  out  1  fetch stopped on ebreak (only meaningful with feature enabled)

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - fetch_pc = RESET_PC, state = REQ, drop = 0.
  - imem_req_valid = 0 while rst is high.
  - inst_valid = 0, instruction = 0, pc = RESET_PC, fetch_err = 0, halted = 0.
- REQ state:
  - imem_req_valid = 1, imem_req_addr = fetch_pc.
  - On imem_req_ready, go to WAIT.
- WAIT state:
  - On imem_rsp_valid with drop = 0: register data into instruction, err into fetch_err, fetch_pc into pc; go to HOLD.
  - On imem_rsp_valid with drop = 1: discard the response, clear drop, go to REQ.
- HOLD state:
  - inst_valid = 1; instruction, pc and fetch_err stay stable until consumed.
  - On inst_ready: fetch_pc = redirect_valid ? redirect_pc : pc + 4; go to REQ.
- Latency: request accepted at cycle t, response at t+k (k ≥ 1), inst_valid rises at t+k+1. Minimum 3 cycles from REQ entry to consume.
- Redirect has priority over sequential fetch in every state:
  - REQ without accept: fetch_pc = redirect_pc; stay in REQ. The request address may change only through a redirect.
  - REQ with accept in the same cycle: fetch_pc = redirect_pc, drop = 1, go to WAIT.
  - WAIT: fetch_pc = redirect_pc, drop = 1. If a response arrives in the same cycle, it is discarded and the state goes directly to REQ with drop cleared.
  - HOLD without inst_ready: discard the held instruction, inst_valid = 0 next cycle, fetch_pc = redirect_pc, go to REQ.
- Arithmetic: pc + 4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000). The redirect target is used unmodified; the low bits are not forced.
- imem_rsp_valid in REQ or HOLD (no request outstanding) is ignored.
- At most one request is outstanding at a time.
- rst asserted mid-transaction: return to reset values immediately. The outstanding response is not tracked; the memory side is reset by the same rst.

Optional Feature:
- Macro IFU_EBREAK_HALT_EN.
- Defined: when the consumed instruction equals 32'h0010_0073 (ebreak), the unit enters HALT instead of REQ.
  - halted = 1.
  - No further requests; inst_valid = 0.
  - Only rst leaves HALT.
- Not defined: no HALT state, halted tied to 0, ebreak is fetched like any other instruction.

Decomposition:
- Shared package npc_pkg:
  - RESET_PC default.
  - INST_EBREAK = 32'h0010_0073.
  - fetch-state enumeration {REQ, WAIT, HOLD, HALT}.
  - XLEN.
- One natural sub-module: ifu_pc_reg, holding the fetch_pc register with its sequential/redirect next-PC selection and reset to RESET_PC.

Test Plan:
- Reset then always-ready memory with 1-cycle latency and inst_ready = 1 → request addresses 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_valid pulses every 3 cycles with matching pc.
- inst_ready held 0 for 5 cycles in HOLD → instruction, pc and fetch_err stable; no new request issued.
- redirect_valid with redirect_pc = 0x8000_0100 during WAIT → the response for the old pc is dropped (inst_valid stays 0); next request address is 0x8000_0100.
- fetch_pc = 0xFFFF_FFFC consumed without redirect → next request address is 0x0000_0000.
- imem_rsp_err = 1 on a response → fetch_err = 1 with that instruction/pc; cleared on the next delivered instruction.
- With IFU_EBREAK_HALT_EN, fetch 0x0010_0073 and consume it → halted = 1, imem_req_valid stays 0 until rst; without the macro, fetch continues at pc + 4.
